// File: rtl/wb_cmd_initiator.sv
// Wishbone classic initiator: one bus cycle per valid/ready command, read data or
// timeout error returned on a valid/ready response port.
module wb_cmd_initiator #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [31:0]          cmd_adr,
  input  logic [31:0]          cmd_dat,
  input  logic [3:0]           cmd_sel,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_dat,
  output logic                 rsp_err,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [3:0]           wbm_sel_o,
  output logic [31:0]          wbm_adr_o,
  output logic [31:0]          wbm_dat_o,
  input  logic                 wbm_ack_i,
  input  logic [31:0]          wbm_dat_i,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned    CNT_W   = 16;
  localparam bit             TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;

  state_e               state_q, state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 busy_q, busy_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_dat_q, rsp_dat_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic                 we_q, we_d;
  logic [3:0]           sel_q, sel_d;
  logic [31:0]          adr_q, adr_d;
  logic [31:0]          dat_q, dat_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    cnt_d       = cnt_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        // ACK takes priority over a coincident timeout
        if (wbm_ack_i) begin
          rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          rsp_dat_d   = 32'h0;
          rsp_err_d   = 1'b1;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      cnt_q       <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      cnt_q       <= cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed bench for wb_cmd_initiator: programmable-wait slave model, response
// scoreboard, STB-length monitor and saturating error-count model.
module tb_wb_cmd_initiator;

  localparam int unsigned TO  = 16;
  localparam int unsigned ECW = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cmd_valid, cmd_ready, cmd_we;
  logic [31:0]    cmd_adr, cmd_dat;
  logic [3:0]     cmd_sel;
  logic           rsp_valid, rsp_ready, rsp_err;
  logic [31:0]    rsp_dat;
  logic           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]     wbm_sel_o;
  logic [31:0]    wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic           busy;
  logic [ECW-1:0] err_cnt;

  wb_cmd_initiator #(.TIMEOUT(TO), .ERR_CNT_W(ECW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Slave model: ACK in STB cycle (ack_wait+1); ack_wait < 0 never acks
  int          ack_wait;
  int          slv_cnt;
  logic [31:0] rd_data;
  logic        stray_ack;
  assign wbm_ack_i = stray_ack ||
                     (wbm_cyc_o && wbm_stb_o && ack_wait >= 0 && slv_cnt == ack_wait);
  assign wbm_dat_i = wbm_ack_i ? rd_data : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (wbm_stb_o && !wbm_ack_i) slv_cnt <= slv_cnt + 1;
    else                         slv_cnt <= 0;
  end

  int stb_seen;
  always @(posedge clk) if (wbm_stb_o) stb_seen = stb_seen + 1;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
  } rsp_t;
  rsp_t sb[$];

  int checks = 0;
  int errors = 0;
  logic [ECW-1:0] exp_ecnt = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int wait_n, input logic [31:0] rd,
                        input int bp, input string tag);
    rsp_t exp;
    int   stb_len;
    int   lat;
    rsp_t got;
    if (wait_n >= 0 && wait_n < int'(TO)) begin
      exp.dat = we ? 32'h0 : rd;
      exp.err = 1'b0;
      stb_len = wait_n + 1;
    end else begin
      exp.dat = 32'h0;
      exp.err = 1'b1;
      stb_len = int'(TO);
      if (exp_ecnt != '1) exp_ecnt = exp_ecnt + ECW'(1);
    end
    ack_wait  = wait_n;
    rd_data   = rd;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    check({tag, ".cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
    sb.push_back(exp);
    @(negedge clk);
    cmd_valid = 1'b0;
    stb_seen  = 0;
    check({tag, ".cyc"}, 32'(wbm_cyc_o), 32'd1);
    check({tag, ".stb"}, 32'(wbm_stb_o), 32'd1);
    check({tag, ".we"},  32'(wbm_we_o), 32'(we));
    check({tag, ".adr"}, wbm_adr_o, adr);
    check({tag, ".dat"}, wbm_dat_o, dat);
    check({tag, ".sel"}, 32'(wbm_sel_o), 32'(sel));
    check({tag, ".busy"}, 32'(busy), 32'd1);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(stb_len + 1));
    check({tag, ".stb_len"}, 32'(stb_seen), 32'(stb_len));
    check({tag, ".cyc_drop"}, 32'(wbm_cyc_o), 32'd0);
    check({tag, ".adr_hold"}, wbm_adr_o, adr);
    for (int i = 0; i < bp; i++) begin
      cmd_valid = 1'b1;
      check({tag, ".bp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".bp_dat"}, rsp_dat, exp.dat);
      check({tag, ".bp_cmd_ready"}, 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check({tag, ".rsp_dat"}, rsp_dat, got.dat);
      check({tag, ".rsp_err"}, 32'(rsp_err), 32'(got.err));
    end else begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ".rsp_clear"}, 32'(rsp_valid), 32'd0);
    check({tag, ".cmd_ready_back"}, 32'(cmd_ready), 32'd1);
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(exp_ecnt));
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_sel = '0; rsp_ready = 1'b0; stray_ack = 1'b0; ack_wait = -1;
    rd_data = '0; stb_seen = 0;
    repeat (3) @(negedge clk);
    check("rst.cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.cyc", 32'(wbm_cyc_o), 32'd0);
    check("rst.adr", wbm_adr_o, 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_cmd(1'b1, 32'h3000_0004, 32'h0000_0055, 4'hF, 0, 32'h1111_2222, 0, "wr0");
    do_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF, 10, 32'h1234_5678, 0, "rd10");
    do_cmd(1'b0, 32'h3000_0020, 32'h0, 4'h3, int'(TO) - 1, 32'hA5A5_A5A5, 0, "ack_edge");
    do_cmd(1'b0, 32'h3800_0000, 32'h0, 4'hF, -1, 32'h0, 0, "tmo");
    do_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF, 2, 32'hCAFE_F00D, 5, "bp");
    do_cmd(1'b1, 32'h3000_000C, 32'h7777_8888, 4'h5, 1, 32'h0, 0, "after_bp");

    for (int i = 1; i < 300; i++)
      do_cmd(1'b0, 32'h3800_0000, 32'h0, 4'hF, -1, 32'h0, 0, "tmo_rep");
    check("err_cnt_sat", 32'(err_cnt), 32'd255);

    // Abort a cycle with reset during the third STB cycle
    ack_wait  = -1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0040; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rstbus.stb_before", 32'(wbm_stb_o), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstbus.cyc", 32'(wbm_cyc_o), 32'd0);
    check("rstbus.stb", 32'(wbm_stb_o), 32'd0);
    check("rstbus.rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    exp_ecnt = '0;
    @(negedge clk);
    check("rstbus.cmd_ready", 32'(cmd_ready), 32'd1);
    check("rstbus.err_cnt", 32'(err_cnt), 32'd0);
    stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    stray_ack = 1'b0;
    check("stray.rsp_valid", 32'(rsp_valid), 32'd0);
    check("stray.busy", 32'(busy), 32'd0);
    check("stray.cmd_ready", 32'(cmd_ready), 32'd1);
    do_cmd(1'b0, 32'h3000_0044, 32'h0, 4'hF, 3, 32'h0BAD_CAFE, 0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
